// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-bus handshake between the fetch sequencer and the instruction memory.
// The requester drives one outstanding request; the responder answers it with data_ok.
interface fetch_pc_ctrl_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_data_ok,
    output iresp_data
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, issues instruction-bus requests, squashes
// responses overtaken by a redirect, and presents one instruction at a time to decode.
module fetch_pc_ctrl #(
  parameter logic [63:0] PC_INIT = 64'h0000_0000_8000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_pc_ctrl_if.master        ibus,
  output logic                   f_valid,
  output logic [63:0]            f_pc,
  output logic [31:0]            f_instr,
  input  logic                   stall,
  input  logic                   is_mret,
  input  logic [63:0]            mepc,
  input  logic                   is_intexc,
  input  logic [63:0]            mtvec,
  input  logic                   branch_taken,
  input  logic [63:0]            pc_branch,
  output logic [31:0]            squash_cnt
);

  typedef enum logic [0:0] {StReq, StHold} state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic        pend_valid_q;
  logic [63:0] pend_target_q;

  logic        redir;
  logic [63:0] redir_target;

  // Same priority as the fetch PC mux: mret over trap over branch.
  always_comb begin
    redir        = is_mret | is_intexc | branch_taken;
    redir_target = pc_branch;
    if (is_mret) begin
      redir_target = mepc;
    end else if (is_intexc) begin
      redir_target = mtvec;
    end
  end

  assign ibus.ireq_valid = (state_q == StReq) && !reset;
  assign ibus.ireq_addr  = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StReq;
      pc_q          <= PC_INIT;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 64'd0;
      f_valid       <= 1'b0;
      f_pc          <= 64'd0;
      f_instr       <= 32'd0;
      squash_cnt    <= 32'd0;
    end else begin
      unique case (state_q)
        StReq: begin
          if (ibus.iresp_data_ok) begin
            if (redir || pend_valid_q) begin
              // Response belongs to the abandoned path; drop it and restart at the target.
              squash_cnt   <= squash_cnt + 32'd1;
              pc_q         <= redir ? redir_target : pend_target_q;
              pend_valid_q <= 1'b0;
            end else begin
              f_pc    <= pc_q;
              f_instr <= ibus.iresp_data;
              f_valid <= 1'b1;
              state_q <= StHold;
            end
          end else if (redir) begin
            // Address must stay stable until the response; remember where to go next.
            pend_target_q <= redir_target;
            pend_valid_q  <= 1'b1;
          end
        end
        StHold: begin
          if (redir) begin
            f_valid <= 1'b0;
            pc_q    <= redir_target;
            state_q <= StReq;
          end else if (!stall) begin
            f_valid <= 1'b0;
            pc_q    <= pc_q + 64'd4;
            state_q <= StReq;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Sequences the fetch stage. Owns the architectural fetch PC register and drives the instruction-bus request handshake.
- Resolves redirects (mret, trap entry, taken branch) with the same priority as the fetch PC mux.
- Buffers a redirect that arrives while a fetch is outstanding, so the stale response is squashed.
- Presents one fetched instruction at a time to decode, honouring a decode stall.

Parameters:
- PC_INIT, 64'h0000_0000_8000_0000, fetch PC value after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ireq_valid  out  1  instruction fetch request valid
- ireq_addr  out  64  fetch address (u64)
- iresp_data_ok  in  1  fetch response valid for the outstanding request
- iresp_data  in  32  fetched instruction word
- f_valid  out  1  fetched instruction presented to decode
- f_pc  out  64  PC of the presented instruction
- f_instr  out  32  presented instruction
- stall  in  1  decode not ready; holds the presented instruction
- is_mret  in  1  redirect to mepc
- mepc  in  64  mret target
- is_intexc  in  1  redirect to mtvec (interrupt/exception)
- mtvec  in  64  trap target
- branch_taken  in  1  redirect to pc_branch
- pc_branch  in  64  branch target
- squash_cnt  out  32  count of squashed fetch responses

Behaviour:
- Reset state: pc=PC_INIT, state=REQ, pend_valid=0, pend_target=0, f_valid=0, f_pc=0, f_instr=0, squash_cnt=0.
  - ireq_valid is 0 in any cycle where reset=1.
  - Reset asserted mid-request abandons the request. A response arriving in the first cycle after reset is treated as belonging to the new request (bus contract).
- Redirect resolution (combinational): redir = is_mret | is_intexc | branch_taken.
  - Target priority: mepc if is_mret, else mtvec if is_intexc, else pc_branch.
  - Redirect inputs are single-cycle pulses.
- States: REQ, HOLD.
- REQ:
  - ireq_valid=1 and ireq_addr=pc. ireq_addr stays stable until iresp_data_ok; pc never changes while a request is outstanding without a response.
  - redir and no data_ok: pend_target<=resolved target, pend_valid<=1. A later redirect overwrites a pending one (the newer event is younger and more authoritative). Stay REQ.
  - data_ok with redir or pend_valid: squash the response (f_valid stays 0) and squash_cnt++ (wraps at 2^32).
    - pc<=this cycle's resolved target if redir, else pend_target.
    - pend_valid<=0. Stay REQ; the new address is issued the next cycle.
  - data_ok, no redir, no pend_valid: f_pc<=pc, f_instr<=iresp_data, f_valid<=1, go HOLD.
- HOLD:
  - ireq_valid=0; f_valid, f_pc and f_instr are stable.
  - redir (takes precedence over stall): f_valid<=0, pc<=resolved target, go REQ. The held instruction is dropped and not counted in squash_cnt.
  - no redir, stall=1: stay HOLD, outputs unchanged.
  - no redir, stall=0: instruction consumed this cycle. f_valid<=0, pc<=pc+4 (64-bit, wrap mod 2^64), go REQ.
- Latency:
  - The instruction is presented the cycle after data_ok.
  - The next request issues the cycle after consumption.
  - Zero-wait-state bus peak throughput: one instruction per 2 cycles.
- pend_valid is never 1 in HOLD.
- All outputs are registered except ireq_valid and ireq_addr, which decode from state and pc.

Test Plan:
- Reset, bus returns data_ok one cycle after each request with 32'h00000013, stall=0 → ireq_addr sequence 0x80000000, 0x80000004, 0x80000008; f_valid pulses with matching f_pc; squash_cnt=0.
- Request at 0x80000000, branch_taken with pc_branch=0x80000100 two cycles before data_ok (data_ok 3 cycles late) → ireq_addr held at 0x80000000 until data_ok; response squashed, no f_valid; next ireq_addr=0x80000100; squash_cnt=1.
- Same cycle is_mret (mepc=0x80000200), is_intexc (mtvec=0x80000300) and branch_taken, coincident with data_ok → response squashed; next ireq_addr=0x80000200.
- HOLD with stall=1 for 5 cycles → f_valid=1 and f_pc/f_instr constant, ireq_valid=0. Release stall → next ireq_addr=f_pc+4.
- HOLD with stall=1 and is_intexc (mtvec=0x80000400) → f_valid drops next cycle; ireq_addr=0x80000400; squash_cnt unchanged.
- Pending branch (0x80000100) overwritten by is_intexc (0x80000400) before data_ok → fetch resumes at 0x80000400. Reset asserted mid-request → ireq_valid=0 during reset, then ireq_addr=0x80000000, squash_cnt=0.
